// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard/control bundle between the pipeline datapath and the
// stall/flush scheduler.
//   master : pipeline side; drives D/E/M hazard info, MD start and CP0 request,
//            receives register enables, bubble/flush controls, MD status, stall count.
//   slave  : scheduler side (pipe_stall_ctrl); the mirror image of master.
interface pipe_stall_ctrl_if;

  // Hazard information from the D, E and M stages.
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_is_md;
  logic [4:0]  e_wreg;
  logic [1:0]  e_tnew;
  logic [4:0]  m_wreg;
  logic [1:0]  m_tnew;

  // Multiply/divide start and CP0 request.
  logic        e_md_start;
  logic        e_md_div;
  logic        int_req;

  // Pipeline register controls and status.
  logic        pc_en;
  logic        fd_en;
  logic        de_flush;
  logic        em_en;
  logic        mw_en;
  logic        req;
  logic        md_busy;
  logic        md_start_ok;
  logic [31:0] stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    output e_wreg, e_tnew, m_wreg, m_tnew,
    output e_md_start, e_md_div, int_req,
    input  pc_en, fd_en, de_flush, em_en, mw_en, req,
    input  md_busy, md_start_ok, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    input  e_wreg, e_tnew, m_wreg, m_tnew,
    input  e_md_start, e_md_div, int_req,
    output pc_en, fd_en, de_flush, em_en, mw_en, req,
    output md_busy, md_start_ok, stall_cnt
  );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush scheduler for the 5-stage MIPS pipeline.
//
// Each cycle it decides, from Tuse/Tnew register hazards, multiply/divide unit
// occupancy and the CP0 request, whether D must be held (PC and F/D frozen, a
// bubble inserted into D/E) or the whole pipeline flushed (req). It also owns
// the MD busy counter so the MD unit itself needs no busy output.
//
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : pipe_stall_ctrl_if.slave
//            inputs  d_rs/d_rt/d_tuse_rs/d_tuse_rt/d_is_md, e_wreg/e_tnew,
//                    m_wreg/m_tnew, e_md_start/e_md_div, int_req
//            outputs pc_en, fd_en, de_flush, em_en, mw_en, req, md_busy,
//                    md_start_ok, stall_cnt (hazard-stall cycles since reset)
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4   // must hold DIV_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic hz_rs;
  logic hz_rt;
  logic st_reg;
  logic st_md;
  logic stall;
  logic md_busy;
  logic md_start_ok;
  logic req;

  // An operand stalls when a producer in E or M will not have its value ready
  // by the time D needs it (Tnew > Tuse). $0 and unused operands never stall.
  function automatic logic operand_hazard(
    input logic [4:0] rsel,
    input logic [1:0] tuse,
    input logic [4:0] e_wreg,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wreg,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (rsel == e_wreg) && (e_tnew > tuse);
    m_hit = (rsel == m_wreg) && (m_tnew > tuse);
    return (rsel != 5'd0) && (tuse != 2'd3) && (e_hit || m_hit);
  endfunction

  //--------------------------------------------------------------------------
  // Stall / flush decision
  //--------------------------------------------------------------------------
  always_comb begin
    hz_rs = operand_hazard(bus.d_rs, bus.d_tuse_rs, bus.e_wreg, bus.e_tnew,
                           bus.m_wreg, bus.m_tnew);
    hz_rt = operand_hazard(bus.d_rt, bus.d_tuse_rt, bus.e_wreg, bus.e_tnew,
                           bus.m_wreg, bus.m_tnew);
  end

  assign st_reg  = hz_rs | hz_rt;
  assign md_busy = (state_q == StBusy);

  // An MD instruction in D waits while the unit is occupied or being started
  // in this very cycle by the instruction in E.
  assign st_md   = bus.d_is_md & (md_busy | bus.e_md_start);

  // The request has priority over any stall; during reset everything is
  // released so the pipeline registers can take their own reset values.
  assign req     = bus.int_req & ~reset;
  assign stall   = (st_reg | st_md) & ~bus.int_req & ~reset;

  // A start squashed by the request must not occupy the MD unit.
  assign md_start_ok = bus.e_md_start & ~bus.int_req;

  assign bus.pc_en       = ~stall;
  assign bus.fd_en       = ~stall;
  assign bus.de_flush    = stall;
  // Stages downstream of D always drain; a flush is handled by req itself.
  assign bus.em_en       = 1'b1;
  assign bus.mw_en       = 1'b1;
  assign bus.req         = req;
  assign bus.md_busy     = md_busy;
  assign bus.md_start_ok = md_start_ok;
  assign bus.stall_cnt   = stall_cnt_q;

  //--------------------------------------------------------------------------
  // MD occupancy FSM
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (md_start_ok) begin
          state_d = StBusy;
          cnt_d   = bus.e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      StBusy: begin
        // A start while busy cannot legally happen (st_md holds MD ops in D),
        // so it is ignored rather than reloading the count. The request does
        // not abort an operation in flight.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Hazard-stall counter; wraps naturally at 2^32.
  //--------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
